fp_add_pipe: RTL and testbench
==============================

Name: fp_add_pipe

Overview:
Parametrised successor to the fixed 4-phase float adder.
- Fully pipelined IEEE-754-style adder/subtractor, generic exponent and mantissa widths.
- valid/ready handshake with back-pressure replaces switch-stepped register enables; one operation accepted per cycle.
- Adds effective subtraction, leading-zero normalisation, overflow/zero flags and per-stage occupancy outputs for board LEDs.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width, hidden bit excluded.
- W, 1+EXP_W+MAN_W, derived total word width; not overridable.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept this cycle.
- op_sub  in  1  1 computes a-b, 0 computes a+b.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  sign|exponent|mantissa.
- overflow  out  1  result saturated to infinity.
- zero  out  1  result is zero.
- stage_busy  out  4  bit k set means stage k+1 holds a valid op.

Behaviour:
- Reset (reset==0 at a clk edge): clears all stage valids.
  - out_valid=0, result=0, overflow=0, zero=0, stage_busy=0.
  - in_ready=1 in the cycle after reset.
  - Ops in flight are discarded, including mid-pipeline reset.
- Pipeline: 4 register stages, latency 4 cycles from accept to out_valid with no stall. Throughput 1/cycle.
- Advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - All stages shift together when adv=1 and hold when adv=0.
  - Bubbles are not compressed.
- Transfers:
  - Accept occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - result, overflow and zero are stable while out_valid=1 and out_ready=0.
- S1, compare/swap:
  - Effective B sign = b.sign ^ op_sub.
  - Exponent-0 operands are treated as zero (subnormals flushed); the hidden bit is 1 otherwise.
  - Larger magnitude is chosen by {exp,man} compare; on a tie, A is larger.
  - diff = exp_large - exp_small.
- S2, align:
  - Small significand shifted right by diff into a MAN_W+4-bit datapath (hidden, mantissa, guard, round, sticky).
  - Sticky ORs all shifted-out bits.
  - diff >= MAN_W+3 leaves only sticky.
- S3, add/sub:
  - Equal effective signs: add, carry-out possible.
  - Otherwise: subtract small from large; the result is non-negative.
  - Result sign = sign of the larger operand.
- S4, normalise/round:
  - On carry: shift right 1, exp+1, with sticky accumulation.
  - Otherwise: shift left by the leading-zero count, exp-lzc.
  - If lzc >= exp_large, or the sum is 0: result = +0, zero=1.
  - Exact cancellation gives +0.
- Overflow:
  - Triggered when the final exponent reaches 2^EXP_W-1 (including after rounding).
  - result = {sign, all-ones, 0}, overflow=1.
- Rounding: truncation by default (see optional feature).
- Inputs with exponent all-ones: treated as normal numbers; no NaN/Inf semantics.

Optional Feature:
- FP_ROUND_EN defined: S4 applies round-to-nearest-even using guard/round/sticky.
  - A mantissa rollover increments the exponent and may raise overflow.
- FP_ROUND_EN undefined: guard/round/sticky are dropped (truncate); latency is unchanged.

Decomposition:
- Package fp_pkg holds:
  - localparams for the default EXP_W/MAN_W.
  - Typedef fp_word_t (packed struct sign/exp/man).
  - Stage-register struct typedefs s1_t..s4_t.
  - Helper constants EXP_MAX and EXT_W=MAN_W+4.
- One sub-module: fp_lzc, a parametrised combinational leading-zero counter over EXT_W+1 bits, instantiated in S4.

Test Plan (EXP_W=8, MAN_W=23):
- 0x3F800000 + 0x3F800000, out_ready=1 → 0x40000000 exactly 4 cycles after accept; zero=0, overflow=0.
- 0x3FC00000 with op_sub=1 minus 0x3FC00000 → 0x00000000, zero=1; also 0x40400000 - 0x3F800000 → 0x40000000.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1.
- 0x3F800001 + 0x33800000:
  - With FP_ROUND_EN → 0x3F800002.
  - Without → 0x3F800001.
  - 0x3F800000 + 0x33800000 → 0x3F800000 in both builds.
- Back-pressure:
  - Setup: 6 back-to-back ops, out_ready held 0 for 3 cycles after first out_valid.
  - in_ready=0 during the stall, no op lost or duplicated, results in order.
  - stage_busy=4'b1111 while stalled.
- Reset: reset=0 for 1 cycle with 3 ops in flight → next cycle out_valid=0, stage_busy=0, in_ready=1; the next op completes normally in 4 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and types for the pipelined float adder fp_add_pipe.
// The stage structs describe the default 8-bit exponent / 23-bit mantissa layout.
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int EXT_W    = FP_MAN_W + 4;
   localparam logic [FP_EXP_W-1:0] EXP_MAX = '1;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] expo;
      logic [FP_MAN_W-1:0] man;
   } fp_word_t;

   typedef struct packed {
      logic                sign;
      logic                effSub;
      logic [FP_EXP_W-1:0] expL;
      logic [FP_EXP_W-1:0] diff;
      logic [FP_MAN_W:0]   sigL;
      logic [FP_MAN_W:0]   sigS;
   } s1_t;

   typedef struct packed {
      logic                sign;
      logic                effSub;
      logic [FP_EXP_W-1:0] expL;
      logic [EXT_W-1:0]    sigL;
      logic [EXT_W-1:0]    sigS;
   } s2_t;

   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] expL;
      logic [EXT_W:0]      sum;
   } s3_t;

   typedef struct packed {
      fp_word_t result;
      logic     overflow;
      logic     zero;
   } s4_t;

endpackage

// File: rtl/fp_add_pipe_lzc.sv
// Combinational leading-zero counter used by the S4 normaliser of fp_add_pipe.
// An all-zero input reports N.
module fp_lzc
   import fp_pkg::*;
#(
   parameter  int N  = EXT_W + 1,
   localparam int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  i_value,
   output logic [CW-1:0] o_count
);

   // Scanning upward lets the most significant set bit win.
   always_comb begin
      o_count = CW'(N);
      for (int i = 0; i < N; i++) begin
         if (i_value[i]) o_count = CW'(N - 1 - i);
      end
   end

endmodule

// File: rtl/fp_add_pipe.sv
// Four-stage pipelined float adder/subtractor with valid/ready back-pressure.
// Define FP_ROUND_EN for round-to-nearest-even in S4; otherwise results truncate.
module fp_add_pipe
   import fp_pkg::*;
#(
   parameter  int EXP_W = FP_EXP_W,
   parameter  int MAN_W = FP_MAN_W,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op_sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         overflow,
   output logic         zero,
   output logic [3:0]   stage_busy
);

   localparam int XW = MAN_W + 4;
   localparam int CW = $clog2(XW + 2);
   localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};

   typedef struct packed {
      logic             sign;
      logic             effSub;
      logic [EXP_W-1:0] expL;
      logic [EXP_W-1:0] diff;
      logic [MAN_W:0]   sigL;
      logic [MAN_W:0]   sigS;
   } st1_t;

   typedef struct packed {
      logic             sign;
      logic             effSub;
      logic [EXP_W-1:0] expL;
      logic [XW-1:0]    sigL;
      logic [XW-1:0]    sigS;
   } st2_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] expL;
      logic [XW:0]      sum;
   } st3_t;

   logic r_v1, r_v2, r_v3, r_v4;
   st1_t r_s1, w_s1;
   st2_t r_s2, w_s2;
   st3_t r_s3, w_s3;
   logic [W-1:0] r_result, w_result;
   logic r_overflow, w_overflow, r_zero, w_zero;
   logic w_adv;

   assign w_adv      = ~r_v4 | out_ready;
   assign in_ready   = w_adv;
   assign out_valid  = r_v4;
   assign result     = r_result;
   assign overflow   = r_overflow;
   assign zero       = r_zero;
   assign stage_busy = {r_v4, r_v3, r_v2, r_v1};

   // S1: subnormals flush to zero; a magnitude tie keeps A as the larger operand.
   logic [EXP_W-1:0] w_expA, w_expB;
   logic [MAN_W:0]   w_sigA, w_sigB;
   logic             w_signB, w_aBig;

   assign w_expA  = a[W-2:MAN_W];
   assign w_expB  = b[W-2:MAN_W];
   assign w_sigA  = (w_expA == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
   assign w_sigB  = (w_expB == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
   assign w_signB = b[W-1] ^ op_sub;
   assign w_aBig  = a[W-2:0] >= b[W-2:0];

   always_comb begin
      w_s1.sign   = w_aBig ? a[W-1] : w_signB;
      w_s1.effSub = a[W-1] ^ w_signB;
      w_s1.expL   = w_aBig ? w_expA : w_expB;
      w_s1.diff   = w_aBig ? (w_expA - w_expB) : (w_expB - w_expA);
      w_s1.sigL   = w_aBig ? w_sigA : w_sigB;
      w_s1.sigS   = w_aBig ? w_sigB : w_sigA;
   end

   logic [XW-1:0] w_extS, w_shS;
   logic          w_lost;

   assign w_extS = {r_s1.sigS, 3'b000};
   assign w_shS  = w_extS >> r_s1.diff;

   // S2: everything shifted past the sticky position folds into it.
   always_comb begin
      w_lost = 1'b0;
      for (int i = 0; i < XW; i++) begin
         if (i < int'(r_s1.diff)) w_lost = w_lost | w_extS[i];
      end
      w_s2.sign   = r_s1.sign;
      w_s2.effSub = r_s1.effSub;
      w_s2.expL   = r_s1.expL;
      w_s2.sigL   = {r_s1.sigL, 3'b000};
      w_s2.sigS   = {w_shS[XW-1:1], w_shS[0] | w_lost};
   end

   always_comb begin
      w_s3.sign = r_s2.sign;
      w_s3.expL = r_s2.expL;
      if (r_s2.effSub) w_s3.sum = {1'b0, r_s2.sigL} - {1'b0, r_s2.sigS};
      else             w_s3.sum = {1'b0, r_s2.sigL} + {1'b0, r_s2.sigS};
   end

   logic [CW-1:0]    w_lzc, w_lz;
   logic             w_carry, w_roundUp, w_roll, w_isZero;
   logic [XW-1:0]    w_mant;
   logic [EXP_W:0]   w_expPre, w_expFin;
   logic [MAN_W:0]   w_manR;

   fp_lzc #(.N(XW + 1)) u_lzc (
      .i_value(r_s3.sum),
      .o_count(w_lzc)
   );

   assign w_carry = r_s3.sum[XW];
   assign w_lz    = w_lzc - CW'(1);

   // S4: exponents are one bit wider so carry/rounding past all-ones is visible.
   always_comb begin
      if (w_carry) begin
         w_mant   = {r_s3.sum[XW:2], r_s3.sum[1] | r_s3.sum[0]};
         w_expPre = {1'b0, r_s3.expL} + (EXP_W+1)'(1);
      end else begin
         w_mant   = XW'(r_s3.sum << w_lz);
         w_expPre = {1'b0, r_s3.expL} - (EXP_W+1)'(w_lz);
      end
   end

`ifdef FP_ROUND_EN
   assign w_roundUp = w_mant[2] & (w_mant[1] | w_mant[0] | w_mant[3]);
`else
   assign w_roundUp = 1'b0 & (|w_mant[2:0]);
`endif

   assign w_manR   = {1'b0, w_mant[XW-2:3]} + (MAN_W+1)'(w_roundUp);
   assign w_roll   = w_manR[MAN_W];
   assign w_expFin = w_expPre + (EXP_W+1)'(w_roll);
   assign w_isZero = ~w_mant[XW-1] | (~w_carry & (int'(w_lz) >= int'(r_s3.expL)));

   always_comb begin
      w_zero     = 1'b0;
      w_overflow = 1'b0;
      w_result   = {r_s3.sign, w_expFin[EXP_W-1:0], w_manR[MAN_W-1:0]};
      if (w_isZero) begin
         w_result = '0;
         w_zero   = 1'b1;
      end else if (w_expFin >= EMAX) begin
         w_result   = {r_s3.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_overflow = 1'b1;
      end
   end

   // All stages advance or hold together; bubbles travel with the data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_v1       <= 1'b0;
         r_v2       <= 1'b0;
         r_v3       <= 1'b0;
         r_v4       <= 1'b0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
      end else if (w_adv) begin
         r_v1       <= in_valid;
         r_v2       <= r_v1;
         r_v3       <= r_v2;
         r_v4       <= r_v3;
         r_s1       <= w_s1;
         r_s2       <= w_s2;
         r_s3       <= w_s3;
         r_result   <= w_result;
         r_overflow <= w_overflow;
         r_zero     <= w_zero;
      end
   end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe: vector table, back-pressure, reset and latency sequences.
// Rounding-sensitive expectations follow whether FP_ROUND_EN is defined for the build.
module tb_fp_add_pipe;
   import fp_pkg::*;

`ifdef FP_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   localparam int NV = 17;
   localparam logic [31:0] POS_INF = {1'b0, EXP_MAX, {FP_MAN_W{1'b0}}};

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic        ovf;
      logic        zro;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic        ovf;
      logic        zro;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, inValid, inReady, opSub, outValid, outReady, ovf, zro;
   logic [31:0] opA, opB, res;
   logic [3:0]  busy;

   vec_t vecs[NV];
   exp_t sb[$];
   exp_t mon;
   int   total = 0;
   int   bad = 0;
   int   popCount = 0;
   int   bpBase;
   bit   stressOn;

   fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
      .op_sub(opSub), .a(opA), .b(opB), .out_valid(outValid),
      .out_ready(outReady), .result(res), .overflow(ovf), .zero(zro),
      .stage_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
      end
   endtask

   // Drives one operation and waits (bounded) for it to be accepted.
   task automatic applyStimulus(input int id);
      int n;
      opA = vecs[id].a;
      opB = vecs[id].b;
      opSub = vecs[id].sub;
      inValid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!inReady && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput($sformatf("accept id%0d", id), 32'(inReady), 32'd1);
      if (inReady) sb.push_back('{id, vecs[id].res, vecs[id].ovf, vecs[id].zro});
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   task automatic checkLatency(input int id);
      int cyc;
      applyStimulus(id);
      cyc = 1;
      while (!outValid && cyc < 12) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checkOutput($sformatf("latency id%0d", id), 32'(cyc), 32'd4);
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput({name, " drain"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, " out_valid"}, 32'(outValid), 32'd0);
      checkOutput({name, " stage_busy"}, 32'(busy), 32'd0);
      checkOutput({name, " in_ready"}, 32'(inReady), 32'd1);
      checkOutput({name, " result"}, res, 32'd0);
      checkOutput({name, " overflow"}, 32'(ovf), 32'd0);
      checkOutput({name, " zero"}, 32'(zro), 32'd0);
   endtask

   // Scoreboard: every output transfer must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset && outValid && outReady) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected out_valid", 32'(outValid), 32'd0);
         end else begin
            mon = sb.pop_front();
            popCount++;
            checkOutput($sformatf("result id%0d", mon.id), res, mon.res);
            checkOutput($sformatf("overflow id%0d", mon.id), 32'(ovf), 32'(mon.ovf));
            checkOutput($sformatf("zero id%0d", mon.id), 32'(zro), 32'(mon.zro));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0};
      vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b1};
      vecs[2]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0};
      vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, POS_INF, 1'b1, 1'b0};
      vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, RND ? 32'h3F800002 : 32'h3F800001, 1'b0, 1'b0};
      vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
      vecs[6]  = '{32'h40000000, 32'hC0000000, 1'b0, 32'h00000000, 1'b0, 1'b1};
      vecs[7]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0};
      vecs[8]  = '{32'h40400000, 32'h3F000000, 1'b0, 32'h40600000, 1'b0, 1'b0};
      vecs[9]  = '{32'h00000005, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
      vecs[10] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b1};
      vecs[11] = '{32'hC0000000, 32'hC0000000, 1'b1, 32'h00000000, 1'b0, 1'b1};
      vecs[12] = '{32'h4B800000, 32'h3FC00000, 1'b0, RND ? 32'h4B800001 : 32'h4B800000, 1'b0, 1'b0};
      vecs[13] = '{32'h7F800000, 32'h00000000, 1'b0, POS_INF, 1'b1, 1'b0};
      vecs[14] = '{32'h4F000000, 32'h3F800000, 1'b0, 32'h4F000000, 1'b0, 1'b0};
      vecs[15] = '{32'h4F000000, 32'h3F800000, 1'b1, RND ? 32'h4F000000 : 32'h4EFFFFFF, 1'b0, 1'b0};
      vecs[16] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, RND ? POS_INF : 32'h7F7FFFFF, RND, 1'b0};

      reset = 1'b0;
      inValid = 1'b0;
      opSub = 1'b0;
      opA = '0;
      opB = '0;
      outReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");
      reset = 1'b1;

      checkLatency(0);
      waitDrain("latency");

      for (int i = 0; i < NV; i++) applyStimulus(i);
      waitDrain("table");

      // Same table again with the consumer randomly stalling.
      stressOn = 1'b1;
      fork
         begin
            for (int i = 0; i < NV; i++) applyStimulus(i);
            stressOn = 1'b0;
         end
         begin
            while (stressOn) begin
               @(posedge clk);
               #2;
               outReady = 1'($urandom_range(0, 1));
            end
            outReady = 1'b1;
         end
      join
      waitDrain("stress");

      // Six back-to-back ops, consumer stalls three cycles at the first result.
      bpBase = popCount;
      outReady = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) applyStimulus(i);
         end
         begin
            int n;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!outValid && n < 50);
            checkOutput("bp first out_valid", 32'(outValid), 32'd1);
            for (int k = 0; k < 3; k++) begin
               if (k > 0) @(negedge clk);
               checkOutput($sformatf("bp in_ready c%0d", k), 32'(inReady), 32'd0);
               checkOutput($sformatf("bp stage_busy c%0d", k), 32'(busy), 32'hF);
               checkOutput($sformatf("bp held result c%0d", k), res, vecs[0].res);
            end
            @(posedge clk);
            #1;
            outReady = 1'b1;
         end
      join
      waitDrain("backpressure");
      checkOutput("bp transfer count", 32'(popCount - bpBase), 32'd6);

      // Reset with three ops in flight; they must vanish.
      outReady = 1'b1;
      for (int i = 6; i < 9; i++) applyStimulus(i);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      checkResetState("mid reset");
      checkLatency(7);
      waitDrain("after reset");
      repeat (6) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
